dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter and stall controller for the single-cycle core's data memory port. The core's load/store path and an external host port share the single DataMemory port. The host port is used for program/data loading and memory dumps. The core has default priority; a bounded-wait counter guarantees host progress by asserting the core's `pause` input and stealing the port.

## Interface
Parameters:
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `MAX_WAIT`, default 4: host wait cycles before a steal is forced. Range 1..15.
- `BURST_LEN`, default 4: maximum host transfers per steal. Used only with `DMEM_ARB_BURST_EN`.

Ports:
- `CLOCK_50` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `cpu_mem_read` in 1: core load request, from the core's MemRead.
- `cpu_mem_write` in 1: core store request, from the core's MemWrite.
- `cpu_address` in ADDR_W: core address, from ALU_result.
- `cpu_write_data` in DATA_W: core store data.
- `cpu_read_data` out DATA_W: load data returned to the core.
- `cpu_pause` out 1: registered; drives the core's `pause`.
- `host_valid` in 1: host request.
- `host_write` in 1: 1 = write, 0 = read. Qualified by `host_valid`.
- `host_address` in ADDR_W: host address.
- `host_write_data` in DATA_W: host write data.
- `host_ready` out 1: combinational grant. Handshake = `host_valid & host_ready`.
- `host_rdata` out DATA_W: registered host read data.
- `host_rvalid` out 1: one-cycle pulse, `host_rdata` valid.
- `mem_read` out 1: to DataMemory MemRead.
- `mem_write` out 1: to DataMemory MemWrite.
- `mem_address` out ADDR_W: to DataMemory address.
- `mem_write_data` out DATA_W: to DataMemory write data.
- `mem_read_data` in DATA_W: from DataMemory. Combinational read, same cycle.

## Operation
- `cpu_access = cpu_mem_read | cpu_mem_write`.
- States:
  - S_CORE: reset state.
  - S_STEAL: core paused, host owns the port.
- S_CORE:
  - If `cpu_access`=1: core signals are muxed to `mem_*`, `cpu_read_data = mem_read_data`, and `host_ready`=0.
  - If `cpu_access`=0 and `host_valid`=1: the host is granted in the same cycle. `host_ready`=1 and host signals drive `mem_*`.
  - Idle otherwise: `mem_read`=`mem_write`=0.
- Wait counter `wait_cnt` (4 bits):
  - Increments each cycle `host_valid & ~host_ready` in S_CORE.
  - Clears on any host handshake or when `host_valid`=0.
  - When `wait_cnt == MAX_WAIT-1` and the host is still blocked: next state is S_STEAL and `cpu_pause` is set at that edge.
- S_STEAL:
  - `cpu_pause`=1 and `host_ready`=1.
  - Host signals drive `mem_*`. Core requests are ignored: `cpu_read_data`=0, no core write reaches memory.
  - On handshake: next state S_CORE, `cpu_pause` clears at that edge, `wait_cnt` clears.
  - If `host_valid` drops while in S_STEAL: return to S_CORE with no transfer.
- Host read: on a read handshake, `host_rdata <= mem_read_data` at the edge and `host_rvalid`=1 for the following cycle.
- Host write: commits in DataMemory at the handshake edge.
- Reset (asynchronous, any state):
  - State S_CORE, `wait_cnt`=0, `cpu_pause`=0, `host_rvalid`=0, `host_rdata`=0.
  - Combinational outputs follow from the S_CORE rules.
  - A host transfer in flight without a completed edge is dropped; the host must reissue it.

## Timing
- Host grant when the core is idle: 0 cycles, combinational.
- Worst-case host latency from `host_valid` rise to handshake: `MAX_WAIT`+1 cycles.
- `cpu_pause` asserts exactly `MAX_WAIT` edges after the host first blocks. It deasserts on the edge closing the steal transfer.
- The core loses exactly 1 cycle per steal (non-burst).
- `host_rvalid` follows a read handshake by 1 cycle. Back-to-back host reads produce back-to-back `host_rvalid` pulses.
- Simultaneous `cpu_access` and `host_valid` in S_CORE: the core wins; the host waits.
- No combinational path exists from `host_*` inputs to `cpu_pause`.

## Configuration
- `DMEM_ARB_BURST_EN` defined:
  - S_STEAL holds while `host_valid`=1, for up to `BURST_LEN` handshakes.
  - A 3-bit burst counter clears on entry to S_STEAL.
  - Exit to S_CORE occurs after the `BURST_LEN`th handshake or when `host_valid`=0.
- Not defined: exactly one handshake per steal; `BURST_LEN` is ignored.

## Test plan
- Reset released, core idle, host writes 0xDEADBEEF to address 0x10 → `host_ready`=1 in the same cycle, `mem_write`=1. A subsequent host read returns 0xDEADBEEF with `host_rvalid` one cycle later.
- Core issues loads every cycle, host read pending, `MAX_WAIT`=4:
  - `cpu_pause` rises after 4 edges.
  - Host handshake occurs in cycle 5.
  - `cpu_pause` falls the next edge.
  - The core sees `cpu_read_data`=0 during the steal.
- Core store and host write to 0x20 in the same S_CORE cycle → the core value is written and the host is not granted. The host write lands later and the final contents equal the host value.
- Reset asserted mid-S_STEAL → `cpu_pause`, `host_rvalid`, and `host_rdata` go to 0 immediately without a clock edge, and the state returns to S_CORE.
- With `DMEM_ARB_BURST_EN`, `BURST_LEN`=4, host streams 6 writes under full core load → 4 writes in one steal with a single `cpu_pause` window of 4 cycles, then a second steal for the remaining 2.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Shares the data memory port between the core load/store path and a host port.
// Defining DMEM_ARB_BURST_EN lets one steal carry up to BURST_LEN host transfers.
module dmem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_WAIT  = 4,
  parameter int BURST_LEN = 4
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              cpu_mem_read,
  input  logic              cpu_mem_write,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_write_data,
  output logic [DATA_W-1:0] cpu_read_data,
  output logic              cpu_pause,
  input  logic              host_valid,
  input  logic              host_write,
  input  logic [ADDR_W-1:0] host_address,
  input  logic [DATA_W-1:0] host_write_data,
  output logic              host_ready,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data
);

  typedef enum logic {S_CORE, S_STEAL} state_t;

  localparam logic [3:0] WAIT_LAST = 4'(MAX_WAIT - 1);

  state_t            state_q;
  logic [3:0]        wait_q;
  logic              pause_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rvalid_q;
  logic              cpu_access;
  logic              host_owns;
  logic              handshake;

`ifdef DMEM_ARB_BURST_EN
  localparam logic [2:0] BURST_LAST = 3'(BURST_LEN - 1);
  logic [2:0] burst_q;
`endif

  // The core keeps the port unless it is idle or a steal is in progress.
  always_comb begin
    cpu_access     = cpu_mem_read | cpu_mem_write;
    host_owns      = (state_q == S_STEAL) | ~cpu_access;
    host_ready     = (state_q == S_STEAL) | (host_valid & ~cpu_access);
    handshake      = host_valid & host_ready;
    mem_read       = cpu_mem_read;
    mem_write      = cpu_mem_write;
    mem_address    = cpu_address;
    mem_write_data = cpu_write_data;
    cpu_read_data  = '0;
    if (host_owns) begin
      mem_read       = host_valid & ~host_write;
      mem_write      = host_valid & host_write;
      mem_address    = host_address;
      mem_write_data = host_write_data;
    end
    if ((state_q == S_CORE) && cpu_access) begin
      cpu_read_data = mem_read_data;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q  <= S_CORE;
      wait_q   <= 4'd0;
      pause_q  <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
`ifdef DMEM_ARB_BURST_EN
      burst_q  <= 3'd0;
`endif
    end else begin
      rvalid_q <= handshake & ~host_write;
      if (handshake & ~host_write) begin
        rdata_q <= mem_read_data;
      end
      case (state_q)
        S_CORE: begin
          // A blocked host ages; on its last allowed wait the core is paused.
          if (host_valid & ~host_ready) begin
            if (wait_q == WAIT_LAST) begin
              state_q <= S_STEAL;
              pause_q <= 1'b1;
              wait_q  <= 4'd0;
`ifdef DMEM_ARB_BURST_EN
              burst_q <= 3'd0;
`endif
            end else begin
              wait_q <= wait_q + 4'd1;
            end
          end else begin
            wait_q <= 4'd0;
          end
        end
        S_STEAL: begin
          wait_q <= 4'd0;
`ifdef DMEM_ARB_BURST_EN
          if (host_valid && (burst_q != BURST_LAST)) begin
            burst_q <= burst_q + 3'd1;
          end else begin
            state_q <= S_CORE;
            pause_q <= 1'b0;
          end
`else
          state_q <= S_CORE;
          pause_q <= 1'b0;
`endif
        end
        default: begin
          state_q <= S_CORE;
          pause_q <= 1'b0;
        end
      endcase
    end
  end

  assign cpu_pause   = pause_q;
  assign host_rdata  = rdata_q;
  assign host_rvalid = rvalid_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed and randomized bench for dmem_arbiter against a cycle-level model of
// the sharing rules, with a small behavioural data memory attached to mem_*.
module tb_dmem_arbiter;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int MAX_WAIT  = 4;
  localparam int BURST_LEN = 4;

  logic              CLOCK_50 = 1'b0;
  logic              reset;
  logic              cpu_mem_read, cpu_mem_write;
  logic [ADDR_W-1:0] cpu_address;
  logic [DATA_W-1:0] cpu_write_data, cpu_read_data;
  logic              cpu_pause;
  logic              host_valid, host_write;
  logic [ADDR_W-1:0] host_address;
  logic [DATA_W-1:0] host_write_data, host_rdata;
  logic              host_ready, host_rvalid;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data, mem_read_data;

  logic [DATA_W-1:0] tbMem [64] = '{default: '0};
  logic [DATA_W-1:0] refMem [64] = '{default: '0};
  bit                mSteal;
  int                mBlocked, mBurst;
  bit                mRvalid;
  logic [DATA_W-1:0] mRdata;
  int                tests = 0;
  int                fails = 0;

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT), .BURST_LEN(BURST_LEN)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write),
    .cpu_address(cpu_address), .cpu_write_data(cpu_write_data),
    .cpu_read_data(cpu_read_data), .cpu_pause(cpu_pause),
    .host_valid(host_valid), .host_write(host_write),
    .host_address(host_address), .host_write_data(host_write_data),
    .host_ready(host_ready), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  // Data memory: combinational read, write committed at the clock edge.
  always #5 CLOCK_50 = ~CLOCK_50;
  assign mem_read_data = tbMem[mem_address[5:0]];
  always @(posedge CLOCK_50) if (mem_write) tbMem[mem_address[5:0]] <= mem_write_data;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                               input logic hv, input logic hw, input logic [31:0] ha, input logic [31:0] hd);
    cpu_mem_read = cr; cpu_mem_write = cw; cpu_address = ca; cpu_write_data = cd;
    host_valid = hv; host_write = hw; host_address = ha; host_write_data = hd;
  endtask

  task automatic modelReset();
    mSteal = 0; mBlocked = 0; mBurst = 0; mRvalid = 0; mRdata = '0;
  endtask

  function automatic bit hostGranted();
    return mSteal || (host_valid && !(cpu_mem_read || cpu_mem_write));
  endfunction

  // Expected port behaviour for the current inputs and the model's state.
  task automatic checkOutput();
    bit cpuAcc, eRd, eWr;
    logic [31:0] eAddr, eWd;
    cpuAcc = cpu_mem_read || cpu_mem_write;
    eRd = 0; eWr = 0; eAddr = '0; eWd = '0;
    if (hostGranted() || (!mSteal && !cpuAcc)) begin
      eRd = host_valid && !host_write; eWr = host_valid && host_write;
      eAddr = host_address; eWd = host_write_data;
    end else if (cpuAcc) begin
      eRd = cpu_mem_read; eWr = cpu_mem_write; eAddr = cpu_address; eWd = cpu_write_data;
    end
    check("host_ready", host_ready, hostGranted());
    check("mem_read", mem_read, eRd);
    check("mem_write", mem_write, eWr);
    if (eRd || eWr) check("mem_address", mem_address, eAddr);
    if (eWr) check("mem_write_data", mem_write_data, eWd);
    check("cpu_pause", cpu_pause, mSteal);
    check("host_rvalid", host_rvalid, mRvalid);
    check("host_rdata", host_rdata, mRdata);
    if (mSteal) check("cpu_read_data_steal", cpu_read_data, 32'h0);
    else if (cpu_mem_read) check("cpu_read_data", cpu_read_data, refMem[cpu_address[5:0]]);
  endtask

  // Advances the model across one clock edge using the inputs of that cycle.
  task automatic updateModel();
    bit hs;
    hs = host_valid && hostGranted();
    mRvalid = hs && !host_write;
    if (hs && !host_write) mRdata = refMem[host_address[5:0]];
    if (hs && host_write) refMem[host_address[5:0]] = host_write_data;
    if (!mSteal && cpu_mem_write) refMem[cpu_address[5:0]] = cpu_write_data;
    if (mSteal) begin
      if (host_valid) begin
        mBurst++;
`ifdef DMEM_ARB_BURST_EN
        if (mBurst == BURST_LEN) mSteal = 0;
`else
        mSteal = 0;
`endif
      end else begin
        mSteal = 0;
      end
    end else if (host_valid && !hs) begin
      mBlocked++;
      if (mBlocked == MAX_WAIT) begin
        mSteal = 1; mBlocked = 0; mBurst = 0;
      end
    end else begin
      mBlocked = 0;
    end
  endtask

  task automatic stepCycle();
    @(negedge CLOCK_50);
    checkOutput();
    @(posedge CLOCK_50);
    updateModel();
    #1;
  endtask

  initial begin
    bit hostReq, hostWr, coreLd, granted;
    logic [31:0] hostAddr, hostData;
    int pauseRuns, firstRun, curRun;

    reset = 1'b0;
    modelReset();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge CLOCK_50);
    #1;
    check("reset_pause", cpu_pause, 1'b0);
    check("reset_rvalid", host_rvalid, 1'b0);
    check("reset_rdata", host_rdata, 32'h0);
    reset = 1'b1;
    stepCycle();

    // Host write then read-back with the core idle.
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h10, 32'hDEADBEEF);
    #1;
    check("idle_grant_ready", host_ready, 1'b1);
    check("idle_grant_mem_write", mem_write, 1'b1);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 1, 0, 32'h10, 32'h0);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    check("readback_rvalid", host_rvalid, 1'b1);
    check("readback_rdata", host_rdata, 32'hDEADBEEF);
    stepCycle();

    // Core loads every cycle while a host read waits.
    applyStimulus(1, 0, 32'h4, 0, 1, 0, 32'h10, 0);
    repeat (MAX_WAIT) stepCycle();
    check("steal_pause_rise", cpu_pause, 1'b1);
    check("steal_cpu_rdata_zero", cpu_read_data, 32'h0);
    check("steal_host_ready", host_ready, 1'b1);
    stepCycle();
    check("steal_pause_fall", cpu_pause, 1'b0);
    check("steal_rvalid", host_rvalid, 1'b1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle();

    // Core store and host write collide on 0x20; the host value lands last.
    applyStimulus(0, 1, 32'h20, 32'h11111111, 1, 1, 32'h20, 32'h22222222);
    #1;
    check("collide_host_blocked", host_ready, 1'b0);
    check("collide_core_data", mem_write_data, 32'h11111111);
    stepCycle();
    applyStimulus(0, 0, 0, 0, 1, 1, 32'h20, 32'h22222222);
    stepCycle();
    applyStimulus(1, 0, 32'h20, 0, 0, 0, 0, 0);
    #1;
    check("collide_final", cpu_read_data, 32'h22222222);
    stepCycle();

    // Asynchronous reset in the middle of a steal.
    applyStimulus(1, 0, 32'h8, 0, 1, 0, 32'h20, 0);
    repeat (MAX_WAIT) stepCycle();
    check("pre_reset_pause", cpu_pause, 1'b1);
    reset = 1'b0;
    #1;
    check("async_reset_pause", cpu_pause, 1'b0);
    check("async_reset_rvalid", host_rvalid, 1'b0);
    check("async_reset_rdata", host_rdata, 32'h0);
    check("async_reset_ready", host_ready, 1'b0);
    modelReset();
    checkOutput();
    @(posedge CLOCK_50);
    #1;
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    stepCycle();

`ifdef DMEM_ARB_BURST_EN
    // Six host writes under full core load split into two steals.
    begin
      int idx, budget;
      idx = 0; budget = 0; pauseRuns = 0; firstRun = 0; curRun = 0;
      while (idx < 6 && budget < 80) begin
        applyStimulus(1, 0, 32'hC, 0, 1, 1, 32'h30 + 32'(idx), 32'hA000 + 32'(idx));
        granted = hostGranted();
        stepCycle();
        if (granted) idx++;
        budget++;
        if (cpu_pause) curRun++;
        else if (curRun != 0) begin
          pauseRuns++;
          if (pauseRuns == 1) firstRun = curRun;
          curRun = 0;
        end
      end
      check("burst_all_done", 32'(idx), 32'd6);
      applyStimulus(1, 0, 32'hC, 0, 0, 0, 0, 0);
      stepCycle();
      if (curRun != 0) pauseRuns++;
      check("burst_steal_count", 32'(pauseRuns), 32'd2);
      check("burst_first_window", 32'(firstRun), 32'(BURST_LEN));
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      stepCycle();
    end
`endif

    // Randomized traffic: a persistent host request against varying core load.
    hostReq = 0; hostWr = 0; hostAddr = '0; hostData = '0;
    for (int i = 0; i < 400; i++) begin
      coreLd = $urandom_range(0, 99) < (((i / 100) % 2 == 1) ? 95 : 40);
      if (!hostReq && $urandom_range(0, 99) < 50) begin
        hostReq = 1; hostWr = $urandom_range(0, 1) == 1;
        hostAddr = 32'($urandom_range(0, 63)); hostData = $urandom;
      end else if (hostReq && $urandom_range(0, 99) < 5) begin
        hostReq = 0;
      end
      if (coreLd) begin
        if ($urandom_range(0, 1) == 1)
          applyStimulus(1, 0, 32'($urandom_range(0, 63)), 0, hostReq, hostWr, hostAddr, hostData);
        else
          applyStimulus(0, 1, 32'($urandom_range(0, 63)), $urandom, hostReq, hostWr, hostAddr, hostData);
      end else begin
        applyStimulus(0, 0, 0, 0, hostReq, hostWr, hostAddr, hostData);
      end
      granted = hostReq && hostGranted();
      stepCycle();
      if (granted) hostReq = 0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
